// File: rtl/argmax_stream_sequencer_if.sv
// Logit input stream and packed guess output stream of the argmax sequencer.
// master = producer/consumer side (bench or upstream), slave = sequencer.
interface argmax_stream_sequencer_if #(
   parameter int INPUT_BITS = 16,
   parameter int NUM_DIGITS = 4
);
   logic                    in_valid;
   logic                    in_ready;
   logic [INPUT_BITS-1:0]   in_data;
   logic                    in_last;
   logic                    out_valid;
   logic                    out_ready;
   logic [4*NUM_DIGITS-1:0] out_guess;

   modport master (
      output in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_guess
   );

   modport slave (
      input  in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_guess
   );
endinterface

// File: rtl/argmax_stream_sequencer.sv
// Serial argmax over NUM_CLASSES logits per digit; packs NUM_DIGITS winning
// indices into one guess word. Ties resolve to the highest class index.
module argmax_stream_sequencer #(
   parameter int INPUT_BITS  = 16,
   parameter int NUM_CLASSES = 10,
   parameter int NUM_DIGITS  = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      clear,
   argmax_stream_sequencer_if.slave  bus,
   output logic                      err
);
   localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [3:0]    LAST_CLS = 4'(NUM_CLASSES - 1);
   localparam logic [DW-1:0] LAST_DIG = DW'(NUM_DIGITS - 1);

   generate
      if (NUM_CLASSES > 16 || NUM_CLASSES < 1) begin : g_bad_cfg
         $error("argmax_stream_sequencer: NUM_CLASSES must be 1..16");
      end
   endgenerate

   typedef enum logic [1:0] {COLLECT, COMMIT, DRAIN, OUTPUT} state_t;

   state_t                   state_q, state_d;
   logic [3:0]               cls_cnt, idx_q;
   logic [DW-1:0]            dig_cnt;
   logic signed [INPUT_BITS-1:0] max_q;
   logic [4*NUM_DIGITS-1:0]  guess_q;
   logic                     rdy_q;
   logic                     xfer, set_err, take_new;

   // rdy_q keeps in_ready low while rst_n is asserted and for the release edge
   assign bus.in_ready  = rdy_q && (state_q == COLLECT || state_q == DRAIN);
   assign bus.out_valid = (state_q == OUTPUT);
   assign bus.out_guess = guess_q;

   assign xfer     = bus.in_valid && bus.in_ready;
   assign take_new = (cls_cnt == 4'd0) || ($signed(bus.in_data) >= max_q);

   always_comb begin
      state_d = state_q;
      set_err = 1'b0;
      case (state_q)
         COLLECT: begin
            if (xfer) begin
               if (bus.in_last) begin
                  if (cls_cnt == LAST_CLS) state_d = COMMIT;
                  else                     set_err = 1'b1;
               end else if (cls_cnt == LAST_CLS) begin
                  set_err = 1'b1;
                  state_d = DRAIN;
               end
            end
         end
         DRAIN:   if (xfer && bus.in_last) state_d = COLLECT;
         COMMIT:  state_d = (dig_cnt == LAST_DIG) ? OUTPUT : COLLECT;
         OUTPUT:  if (bus.out_ready) state_d = COLLECT;
         default: state_d = COLLECT;
      endcase
      if (clear) state_d = COLLECT;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= COLLECT;
      else        state_q <= state_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdy_q   <= 1'b0;
         cls_cnt <= '0;
         dig_cnt <= '0;
         idx_q   <= '0;
         max_q   <= '0;
         guess_q <= '0;
         err     <= 1'b0;
      end else begin
         rdy_q <= 1'b1;
         if (clear) begin
            cls_cnt <= '0;
            dig_cnt <= '0;
            err     <= 1'b0;
         end else begin
            if (set_err) err <= 1'b1;
            case (state_q)
               COLLECT: if (xfer) begin
                  if (take_new) begin
                     max_q <= $signed(bus.in_data);
                     idx_q <= cls_cnt;
                  end
                  // counter restarts on any digit end, good or bad
                  if (bus.in_last || cls_cnt == LAST_CLS) cls_cnt <= '0;
                  else                                    cls_cnt <= cls_cnt + 4'd1;
               end
               DRAIN: if (xfer && bus.in_last) cls_cnt <= '0;
               COMMIT: begin
                  for (int k = 0; k < NUM_DIGITS; k++)
                     if (dig_cnt == DW'(k)) guess_q[4*k +: 4] <= idx_q;
                  cls_cnt <= '0;
                  dig_cnt <= (dig_cnt == LAST_DIG) ? '0 : dig_cnt + DW'(1);
               end
               default: ;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_argmax_stream_sequencer.sv
// Directed bench for argmax_stream_sequencer with hand-computed guess words.
module tb_argmax_stream_sequencer;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic clear = 1'b0;
   logic err;
   int   n_chk = 0;
   int   n_pass = 0;
   logic signed [15:0] lg [16];

   always #5 clk = ~clk;

   argmax_stream_sequencer_if #(.INPUT_BITS(16), .NUM_DIGITS(4)) bus ();

   argmax_stream_sequencer #(.INPUT_BITS(16), .NUM_CLASSES(10), .NUM_DIGITS(4)) dut (
      .clk(clk), .rst_n(rst_n), .clear(clear), .bus(bus), .err(err)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
      else n_pass++;
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic fill(input int pk, input logic signed [15:0] pv, input logic signed [15:0] ov);
      for (int i = 0; i < 16; i++) lg[i] = ov;
      lg[pk] = pv;
   endtask

   // sends lg[0..n-1], in_last on the final one; returns #1 after the last transfer edge
   task automatic send_digit(input int n, input bit gaps);
      for (int i = 0; i < n; i++) begin
         int w;
         if (gaps) begin
            bus.in_valid = 1'b0;
            repeat ($urandom_range(0, 2)) step();
         end
         bus.in_valid = 1'b1;
         bus.in_data  = lg[i];
         bus.in_last  = (i == n - 1);
         w = 0;
         while (w < 200) begin
            @(negedge clk);
            if (bus.in_ready) break;
            w++;
         end
         if (w >= 200) chk("in_ready_timeout", 32'd0, 32'd1);
         @(posedge clk); #1;
      end
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
   endtask

   task automatic take_guess(input string tag, input logic [15:0] exp);
      int w = 0;
      while (!bus.out_valid && w < 100) begin step(); w++; end
      chk({tag, "_ov"}, 32'(bus.out_valid), 32'd1);
      chk({tag, "_guess"}, 32'(bus.out_guess), 32'(exp));
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
      chk({tag, "_ov_drop"}, 32'(bus.out_valid), 32'd0);
   endtask

   task automatic guess4(input int a, input int b, input int c, input int d, input bit gaps);
      int p [4];
      p = '{a, b, c, d};
      for (int k = 0; k < 4; k++) begin
         fill(p[k], 16'sd100, -16'sd5);
         send_digit(10, gaps);
      end
   endtask

   initial begin
      bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0; bus.out_ready = 1'b0;
      #12;
      chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_guess", 32'(bus.out_guess), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      @(posedge clk); #1; rst_n = 1'b1;
      step();

      // partial digit, then reset mid-digit
      fill(8, 16'sd100, -16'sd5);
      send_digit(5, 1'b0);
      rst_n = 1'b0; #2;
      chk("midrst_in_ready", 32'(bus.in_ready), 32'd0);
      chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("midrst_err", 32'(err), 32'd0);
      step(); rst_n = 1'b1; step();

      // normal guess 3,7,0,9 with latency checks
      fill(3, 16'sd100, -16'sd5);
      send_digit(10, 1'b0);
      chk("d0_t1_guess", 32'(bus.out_guess), 32'd0);
      step();
      chk("d0_t2_guess", 32'(bus.out_guess), 32'h0003);
      fill(7, 16'sd100, -16'sd5); send_digit(10, 1'b0);
      fill(0, 16'sd100, -16'sd5); send_digit(10, 1'b0);
      fill(9, 16'sd100, -16'sd5); send_digit(10, 1'b0);
      chk("last_t1_ov", 32'(bus.out_valid), 32'd0);
      step();
      chk("last_t2_ov", 32'(bus.out_valid), 32'd1);
      chk("last_t2_guess", 32'(bus.out_guess), 32'h9073);
      for (int c = 0; c < 5; c++) begin
         step();
         chk("hold_ov", 32'(bus.out_valid), 32'd1);
         chk("hold_guess", 32'(bus.out_guess), 32'h9073);
         chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
      end
      take_guess("normal", 16'h9073);
      chk("normal_err", 32'(err), 32'd0);

      // ties and signs
      fill(0, -16'sd1, -16'sd1);             send_digit(10, 1'b0);
      fill(2, 16'sd50, 16'sd0); lg[5] = 16'sd50; send_digit(10, 1'b0);
      fill(4, -16'sd32767, -16'sd32768);     send_digit(10, 1'b0);
      fill(1, 16'sd100, -16'sd5);            send_digit(10, 1'b0);
      take_guess("ties", 16'h1459);

      // short digit: discarded, same nibble refilled
      fill(2, 16'sd100, -16'sd5); send_digit(7, 1'b0);
      step();
      chk("short_err", 32'(err), 32'd1);
      chk("short_guess", 32'(bus.out_guess), 32'h1459);
      fill(6, 16'sd100, -16'sd5); send_digit(10, 1'b0); step();
      chk("after_short_guess", 32'(bus.out_guess), 32'h1456);

      // long digit: drained, next digit lands in nibble 1
      fill(11, 16'sd100, -16'sd5); send_digit(12, 1'b0); step();
      chk("long_guess", 32'(bus.out_guess), 32'h1456);
      fill(2, 16'sd100, -16'sd5); send_digit(10, 1'b0); step();
      chk("after_long_guess", 32'(bus.out_guess), 32'h1426);
      fill(8, 16'sd100, -16'sd5); send_digit(10, 1'b0);
      fill(5, 16'sd100, -16'sd5); send_digit(10, 1'b0);
      take_guess("errs", 16'h5826);
      chk("errs_sticky", 32'(err), 32'd1);

      // clear after 2 committed digits
      fill(1, 16'sd100, -16'sd5); send_digit(10, 1'b0);
      fill(2, 16'sd100, -16'sd5); send_digit(10, 1'b0); step();
      chk("pre_clear_guess", 32'(bus.out_guess), 32'h5821);
      clear = 1'b1; step(); clear = 1'b0;
      chk("clear_err", 32'(err), 32'd0);
      chk("clear_ov", 32'(bus.out_valid), 32'd0);
      chk("clear_guess", 32'(bus.out_guess), 32'h5821);
      guess4(7, 3, 3, 8, 1'b0);
      take_guess("post_clear", 16'h8337);

      // random in_valid gaps
      guess4(3, 7, 0, 9, 1'b1);
      take_guess("gaps", 16'h9073);
      chk("final_err", 32'(err), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1);
   end
endmodule
